inst_bram_loader: RTL and testbench

Host-side initiator for the instruction-memory BRAM port of the LU decomposition tester. It accepts a stream of 32-bit words and packs every three into one CTRL_WIDTH-bit instruction, written as din parts 0/1/2 at consecutive instruction indices. In readback mode it reads instructions and re-emits them as a 32-bit stream. It drives the same addr/en/we/din_part/dout_part signals the tester wrapper exposes.

---
 rtl/inst_loader_pkg.sv | 28 ++
 rtl/inst_part_mux.sv | 20 ++
 rtl/inst_bram_loader.sv | 182 ++++++++++++++++++
 tb/tb_inst_bram_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and helpers for the instruction-memory BRAM loader.
package inst_loader_pkg;

  localparam int unsigned PARTS  = 3;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [3:0] {
    IDLE,
    LD_P0,
    LD_P1,
    LD_P2,
    LD_WR,
    RD_REQ,
    RD_CAP,
    RD_P0,
    RD_P1,
    RD_P2,
    DONE
  } state_e;

  // Low (ctrl_width-64) bits set: the meaningful bits of instruction part 2.
  function automatic logic [WORD_W-1:0] part2_mask(input int unsigned ctrl_width);
    logic [63:0] ones;
    ones = (64'd1 << (ctrl_width - 64)) - 64'd1;
    return ones[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/inst_part_mux.sv
// Selects one 32-bit part of a packed three-part instruction.
module inst_part_mux
  import inst_loader_pkg::*;
(
  input  logic [PARTS*WORD_W-1:0] parts,
  input  logic [1:0]              sel,
  output logic [WORD_W-1:0]       word_c
);

  always_comb begin
    word_c = '0;
    case (sel)
      2'd0:    word_c = parts[0 +: WORD_W];
      2'd1:    word_c = parts[WORD_W +: WORD_W];
      2'd2:    word_c = parts[2*WORD_W +: WORD_W];
      default: word_c = '0;
    endcase
  end

endmodule

// File: rtl/inst_bram_loader.sv
// Packs a 32-bit word stream into instructions written to the instruction BRAM,
// and streams instructions back out of it in readback mode.
module inst_bram_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned CTRL_WIDTH = 72
) (
  input  logic                CLK_100,
  input  logic                RST_IN,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_WIDTH:0] word_count,
  input  logic [WORD_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [WORD_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                busy,
  output logic                done,
  output logic [31:0]         bram_ZYNQ_INST_addr,
  output logic                bram_ZYNQ_INST_en,
  output logic                bram_ZYNQ_INST_we,
  output logic [WORD_W-1:0]   bram_ZYNQ_INST_din_part_0,
  output logic [WORD_W-1:0]   bram_ZYNQ_INST_din_part_1,
  output logic [WORD_W-1:0]   bram_ZYNQ_INST_din_part_2,
  input  logic [WORD_W-1:0]   bram_ZYNQ_INST_dout_part_0,
  input  logic [WORD_W-1:0]   bram_ZYNQ_INST_dout_part_1,
  input  logic [WORD_W-1:0]   bram_ZYNQ_INST_dout_part_2
);

  localparam int unsigned       CNT_W   = ADDR_WIDTH + 1;
  localparam logic [WORD_W-1:0] P2_MASK = part2_mask(CTRL_WIDTH);

  state_e                  state;
  logic [CNT_W-1:0]        index;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        idx_inc;
  logic                    last;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [PARTS*WORD_W-1:0] rd_buf;
  logic [1:0]              part_sel;
  logic [WORD_W-1:0]       mux_word;

  assign idx_inc             = index + CNT_W'(1);
  assign last                = (idx_inc == count);
  assign bram_ZYNQ_INST_addr = 32'(addr);

  inst_part_mux u_part_mux (
    .parts  (rd_buf),
    .sel    (part_sel),
    .word_c (mux_word)
  );

  // Transfer FSM, index counter and all registered outputs.
  always_ff @(posedge CLK_100) begin
    if (RST_IN) begin
      state                     <= IDLE;
      index                     <= '0;
      count                     <= '0;
      addr                      <= '0;
      rd_buf                    <= '0;
      part_sel                  <= '0;
      s_ready                   <= 1'b0;
      m_valid                   <= 1'b0;
      m_data                    <= '0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      bram_ZYNQ_INST_en         <= 1'b0;
      bram_ZYNQ_INST_we         <= 1'b0;
      bram_ZYNQ_INST_din_part_0 <= '0;
      bram_ZYNQ_INST_din_part_1 <= '0;
      bram_ZYNQ_INST_din_part_2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= word_count;
            index <= '0;
            addr  <= '0;
            busy  <= 1'b1;
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (mode) begin
              state             <= RD_REQ;
              bram_ZYNQ_INST_en <= 1'b1;
              bram_ZYNQ_INST_we <= 1'b0;
            end else begin
              state   <= LD_P0;
              s_ready <= 1'b1;
            end
          end
        end
        LD_P0: begin
          if (s_valid) begin
            bram_ZYNQ_INST_din_part_0 <= s_data;
            state                     <= LD_P1;
          end
        end
        LD_P1: begin
          if (s_valid) begin
            bram_ZYNQ_INST_din_part_1 <= s_data;
            state                     <= LD_P2;
          end
        end
        LD_P2: begin
          if (s_valid) begin
            bram_ZYNQ_INST_din_part_2 <= s_data & P2_MASK;
            s_ready                   <= 1'b0;
            bram_ZYNQ_INST_en         <= 1'b1;
            bram_ZYNQ_INST_we         <= 1'b1;
            state                     <= LD_WR;
          end
        end
        LD_WR: begin
          bram_ZYNQ_INST_en <= 1'b0;
          bram_ZYNQ_INST_we <= 1'b0;
          index             <= idx_inc;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= LD_P0;
            s_ready <= 1'b1;
            addr    <= idx_inc[ADDR_WIDTH-1:0];
          end
        end
        RD_REQ: begin
          bram_ZYNQ_INST_en <= 1'b0;
          state             <= RD_CAP;
        end
        // Part 0 goes straight out; parts 1/2 come from the captured buffer.
        RD_CAP: begin
          rd_buf   <= {bram_ZYNQ_INST_dout_part_2, bram_ZYNQ_INST_dout_part_1,
                       bram_ZYNQ_INST_dout_part_0};
          m_data   <= bram_ZYNQ_INST_dout_part_0;
          m_valid  <= 1'b1;
          part_sel <= 2'd1;
          state    <= RD_P0;
        end
        RD_P0: begin
          if (m_ready) begin
            m_data   <= mux_word;
            part_sel <= part_sel + 2'd1;
            state    <= RD_P1;
          end
        end
        RD_P1: begin
          if (m_ready) begin
            m_data   <= mux_word;
            part_sel <= part_sel + 2'd1;
            state    <= RD_P2;
          end
        end
        RD_P2: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            index   <= idx_inc;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state             <= RD_REQ;
              bram_ZYNQ_INST_en <= 1'b1;
              bram_ZYNQ_INST_we <= 1'b0;
              addr              <= idx_inc[ADDR_WIDTH-1:0];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_bram_loader.sv
// Randomized bench for inst_bram_loader against a word-stream/memory model.
module tb_inst_bram_loader;

  localparam int unsigned AW    = 12;
  localparam int unsigned CW    = 72;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] MASK  = 32'hFFFF_FFFF >> (96 - CW);

  logic          CLK_100 = 1'b0;
  logic          RST_IN = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW:0]   word_count = '0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [31:0]   addr;
  logic          en;
  logic          we;
  logic [31:0]   din0, din1, din2;
  logic [95:0]   dout_q = '0;

  always #5 CLK_100 = ~CLK_100;

  inst_bram_loader #(.ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
    .CLK_100                   (CLK_100),
    .RST_IN                    (RST_IN),
    .start                     (start),
    .mode                      (mode),
    .word_count                (word_count),
    .s_data                    (s_data),
    .s_valid                   (s_valid),
    .s_ready                   (s_ready),
    .m_data                    (m_data),
    .m_valid                   (m_valid),
    .m_ready                   (m_ready),
    .busy                      (busy),
    .done                      (done),
    .bram_ZYNQ_INST_addr       (addr),
    .bram_ZYNQ_INST_en         (en),
    .bram_ZYNQ_INST_we         (we),
    .bram_ZYNQ_INST_din_part_0 (din0),
    .bram_ZYNQ_INST_din_part_1 (din1),
    .bram_ZYNQ_INST_din_part_2 (din2),
    .bram_ZYNQ_INST_dout_part_0(dout_q[31:0]),
    .bram_ZYNQ_INST_dout_part_1(dout_q[63:32]),
    .bram_ZYNQ_INST_dout_part_2(dout_q[95:64])
  );

  // BRAM with one-cycle read latency.
  logic [95:0] mem [0:DEPTH-1];
  always @(posedge CLK_100) begin
    if (en) begin
      if (we) mem[addr[AW-1:0]] <= {din2, din1, din0};
      dout_q <= mem[addr[AW-1:0]];
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk96(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk96(name, 96'(act), 96'(exp));
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input bit cond);
    n_chk++;
    if (!cond) begin
      n_bad++;
      $display("FAIL %s: condition false", name);
    end
  endtask

  // Model: golden memory, expected writes {addr, data}, expected readback words.
  logic [95:0]  gold [0:DEPTH-1];
  logic [127:0] exp_wr_q[$];
  logic [31:0]  exp_rd_q[$];
  logic [31:0]  rd_log[$];
  logic [31:0]  words[$];

  int cyc = 0, acc_cyc = 0, last_evt = 0, first_wr = -1, done_cyc = 0;
  int wr_seen = 0, rd_seen = 0, done_seen = 0;
  bit prev_stall = 1'b0, prev_done = 1'b0, acc_pend = 1'b0;
  logic [31:0] prev_m = '0;

  // Compare process: checks every observable event against the model.
  always @(negedge CLK_100) begin
    logic [127:0] e;
    cyc++;
    if (RST_IN) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      acc_pend   = 1'b0;
    end else begin
      chk_true("we_without_en", !(we && !en));
      if (en && we) begin
        wr_seen++;
        last_evt = cyc;
        if (first_wr < 0) first_wr = cyc;
        chk_true("write_expected", exp_wr_q.size() != 0);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          chk32("wr_addr", addr, e[127:96]);
          chk96("wr_data", {din2, din1, din0}, e[95:0]);
        end
      end
      if (m_valid && m_ready) begin
        rd_seen++;
        last_evt = cyc;
        rd_log.push_back(m_data);
        chk_true("m_expected", exp_rd_q.size() != 0);
        if (exp_rd_q.size() != 0) chk32("m_data", m_data, exp_rd_q.pop_front());
      end
      if (prev_stall) begin
        chk_true("stall_valid", m_valid);
        chk32("stall_data", m_data, prev_m);
      end
      prev_stall = m_valid && !m_ready;
      prev_m     = m_data;
      if (!busy) chk_true("idle_quiet", !s_ready && !m_valid && !en && !we && !done);
      if (acc_pend) chk_true("busy_after_start", busy);
      acc_pend = start && !busy;
      if (acc_pend) begin
        acc_cyc  = cyc;
        last_evt = cyc;
        first_wr = -1;
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        chk_int("done_latency", cyc, last_evt + 1);
        chk_true("done_single", !prev_done);
      end
      if (prev_done) chk_true("busy_falls", !busy);
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge CLK_100);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk96({tag, "_ctrl"}, 96'({s_ready, m_valid, busy, done, en, we}), 96'(0));
    chk32({tag, "_addr"}, addr, 32'h0);
    chk96({tag, "_din"}, {din2, din1, din0}, 96'h0);
    chk32({tag, "_mdata"}, m_data, 32'h0);
  endtask

  task automatic start_xfer(input bit m, input int n);
    mode       = m;
    word_count = (AW+1)'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int done0, input int budget);
    int guard = 0;
    while (done_seen == done0 && guard < budget) begin
      tick();
      guard++;
    end
  endtask

  // Load the instructions held in 'words', feeding s_valid per the options.
  task automatic do_load(input bit hold, input bit poke);
    int n, k, guard, done0, wr0;
    bit hs;
    n = words.size() / 3;
    for (int i = 0; i < n; i++) begin
      gold[i] = {words[3*i+2] & MASK, words[3*i+1], words[3*i]};
      exp_wr_q.push_back({32'(i), gold[i]});
    end
    done0 = done_seen;
    wr0   = wr_seen;
    start_xfer(1'b0, n);
    k = 0;
    guard = 0;
    while (k < words.size() && guard < 8 * words.size() + 100) begin
      s_valid = hold ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      s_data  = s_valid ? words[k] : $urandom;
      if (poke) begin
        start      = 1'($urandom_range(0, 1));
        mode       = 1'($urandom_range(0, 1));
        word_count = (AW+1)'($urandom_range(0, 7));
      end
      hs = s_valid && s_ready;
      tick();
      if (hs) k++;
      guard++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    wait_done(done0, 20);
    chk_int("load_writes", wr_seen - wr0, n);
    chk_int("load_done", done_seen - done0, 1);
    chk_true("wr_queue_drained", exp_wr_q.size() == 0);
  endtask

  // Readback n instructions; pat 0 = ready high, 1 = toggle, 2 = random.
  task automatic do_read(input int n, input int pat);
    int guard, done0, rd0;
    bit tog;
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(gold[i][31:0]);
      exp_rd_q.push_back(gold[i][63:32]);
      exp_rd_q.push_back(gold[i][95:64]);
    end
    rd_log.delete();
    done0 = done_seen;
    rd0   = rd_seen;
    start_xfer(1'b1, n);
    tog   = 1'b1;
    guard = 0;
    while (done_seen == done0 && guard < 20 * n + 50) begin
      case (pat)
        0:       m_ready = 1'b1;
        1:       m_ready = tog;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      tick();
      guard++;
    end
    m_ready = 1'b0;
    chk_int("read_words", rd_seen - rd0, 3 * n);
    chk_int("read_done", done_seen - done0, 1);
    chk_true("rd_queue_drained", exp_rd_q.size() == 0);
  endtask

  initial begin
    int n, wr0, done0;
    bit hs;
    logic [31:0] lit [6];

    repeat (3) tick();
    RST_IN = 1'b0;
    check_reset_outputs("reset");

    // Directed load of two instructions with s_valid held high.
    words = '{32'h11, 32'h22, 32'hAABBCCDD, 32'h33, 32'h44, 32'h55};
    do_load(1'b1, 1'b0);
    chk32("model_pin_p2", gold[0][95:64], 32'h0000_00DD);
    chk96("bram_addr0", mem[0], {32'h0000_00DD, 32'h22, 32'h11});
    chk96("bram_addr1", mem[1], {32'h0000_0055, 32'h44, 32'h33});
    chk_int("first_write_latency", first_wr - acc_cyc, 4);
    chk_int("load2_cycles", done_cyc - acc_cyc, 9);

    // Directed readback with ready high, then with 1-0-1 stalls.
    lit = '{32'h11, 32'h22, 32'hDD, 32'h33, 32'h44, 32'h55};
    do_read(2, 0);
    chk_int("rd_log_len", rd_log.size(), 6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++) chk32("rd_literal", rd_log[i], lit[i]);
    chk_int("read2_cycles", done_cyc - acc_cyc, 11);
    do_read(2, 1);
    for (int i = 0; i < 6 && i < rd_log.size(); i++) chk32("rd_stall_literal", rd_log[i], lit[i]);

    // Zero-length transfers in both modes.
    for (int m = 0; m < 2; m++) begin
      wr0   = wr_seen;
      done0 = done_seen;
      start_xfer(1'(m), 0);
      wait_done(done0, 10);
      chk_int("zero_done", done_seen - done0, 1);
      chk_int("zero_latency", done_cyc - acc_cyc, 1);
      chk_int("zero_writes", wr_seen - wr0, 0);
    end

    // Reset after two accepted load words: nothing may be written.
    wr0   = wr_seen;
    done0 = done_seen;
    start_xfer(1'b0, 2);
    n = 0;
    for (int g = 0; g < 20 && n < 2; g++) begin
      s_valid = 1'b1;
      s_data  = 32'hDEAD_0000 + 32'(n);
      hs = s_valid && s_ready;
      tick();
      if (hs) n++;
    end
    s_data = 32'hDEAD_BEEF;
    RST_IN = 1'b1;
    tick();
    RST_IN  = 1'b0;
    s_valid = 1'b0;
    check_reset_outputs("midreset");
    repeat (3) tick();
    chk_int("midreset_writes", wr_seen - wr0, 0);
    chk_int("midreset_done", done_seen - done0, 0);
    words = '{32'hA0, 32'hA1, 32'hA2};
    do_load(1'b1, 1'b0);

    // start pulses during a busy load of three are ignored.
    words.delete();
    for (int i = 0; i < 9; i++) words.push_back($urandom);
    do_load(1'b0, 1'b1);

    // Whole memory in one transfer.
    words.delete();
    for (int i = 0; i < 3 * DEPTH; i++) words.push_back($urandom);
    do_load(1'b1, 1'b0);
    chk_int("full_load_cycles", done_cyc - acc_cyc, 4 * DEPTH + 1);

    // Random loads and readbacks.
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 8);
      words.delete();
      for (int i = 0; i < 3 * n; i++) words.push_back($urandom);
      do_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_read($urandom_range(1, 8), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
